// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: word width, data-memory responder states, wait counter width
package cpu_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        MEMR_IDLE = 2'd0,
        MEMR_WAIT = 2'd1,
        MEMR_RESP = 2'd2
    } memr_state_e;

    // Bits needed to hold values 0..max_val
    function automatic int memr_cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w = w + 1;
        return w;
    endfunction

    // The wait-state counter covers the full 0..15 programmable range
    localparam int MEMR_CNT_W = memr_cnt_width(15);

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous word RAM with write enable and registered read
import cpu_pkg::*;

module mem_array #(
    parameter int DATA_W     = WORD_W,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    // Word storage; contents are deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register only moves on a load, so it holds the last loaded word
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated data-memory responder for the MEM stage; optional MEM_ALIGN_CHECK_EN
import cpu_pkg::*;

module mem_responder #(
    parameter int DATA_W      = WORD_W,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ack_o,
    output logic              stall_o,
    output logic              err_o
);

    localparam int CNT_W = MEMR_CNT_W;

    memr_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]     wdata_q;

    logic                  in_idle;
    logic                  accept;
    logic                  commit;
    logic                  acc_we;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [DATA_W-1:0]     acc_wdata;
    logic                  acc_mis;
    logic [DEPTH_LOG2-1:0] addr_idx;

    assign addr_idx = addr_i[DEPTH_LOG2+1:2];
    assign in_idle  = (state_q == MEMR_IDLE);
    assign accept   = in_idle && req_i;

    // With zero wait states the access happens on the accept edge, so the
    // live inputs are used in IDLE and the captured copy otherwise
    assign acc_we    = in_idle ? we_i      : we_q;
    assign acc_idx   = in_idle ? addr_idx  : idx_q;
    assign acc_wdata = in_idle ? wdata_i   : wdata_q;

    // State and wait counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MEMR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter reload/decrement and the commit strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            MEMR_IDLE: begin
                if (req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = MEMR_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = MEMR_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            MEMR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = MEMR_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MEMR_RESP: begin
                state_d = MEMR_IDLE;
            end
            default: begin
                state_d = MEMR_IDLE;
            end
        endcase
    end

    // Freeze the request fields at accept; later input changes are ignored
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we_i;
            idx_q   <= addr_idx;
            wdata_q <= wdata_i;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q;
    logic err_q;
    logic unused_addr;

    assign acc_mis     = in_idle ? (addr_i[1:0] != 2'b00) : mis_q;
    assign unused_addr = ^addr_i[ADDR_W-1:DEPTH_LOG2+2];

    // Misalignment flag travels with the transaction and surfaces with ack
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mis_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                mis_q <= (addr_i[1:0] != 2'b00);
            end
            err_q <= commit && acc_mis;
        end
    end

    assign err_o = err_q;
`else
    logic unused_addr;

    assign acc_mis     = 1'b0;
    assign unused_addr = ^{addr_i[ADDR_W-1:DEPTH_LOG2+2], addr_i[1:0]};
    assign err_o       = 1'b0;
`endif

    mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (commit && !acc_mis && !rst_i),
        .we_i    (acc_we),
        .idx_i   (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (rdata_o)
    );

    assign ack_o   = (state_q == MEMR_RESP);
    assign stall_o = req_i && !ack_o;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (WAIT_CYCLES=2, DEPTH_LOG2=10)
module tb_mem_responder;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;
    logic        err;

    int vectors;
    int miscompares;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [int];
    logic [31:0] model_rdata;

    mem_responder #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH_LOG2  (10),
        .WAIT_CYCLES (2)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .ack_o   (ack),
        .stall_o (stall),
        .err_o   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic access(input logic a_we, input logic [31:0] a_addr, input logic [31:0] a_wdata,
                          input bit b2b, input bit keep_req, input bit drop, input int exp_lat,
                          input string name);
        int   lat;
        bit   got;
        bit   mis;
        int   idx;
        exp_t e;
        if (!b2b) begin
            @(posedge clk);
            @(negedge clk);
        end
        req   = 1'b1;
        we    = a_we;
        addr  = a_addr;
        wdata = a_wdata;
        idx   = int'(a_addr[11:2]);
        mis   = ALIGN && (a_addr[1:0] != 2'b00);
        if (!mis) begin
            if (a_we) model_mem[idx] = a_wdata;
            else      model_rdata    = model_mem[idx];
        end
        e.rdata = model_rdata;
        e.err   = mis;
        sb.push_back(e);
        #1;
        if (!b2b) begin
            vectors++;
            if (stall !== 1'b1) begin
                miscompares++;
                $display("FAIL %s stall_at_req: got %b want 1", name, stall);
            end
        end
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (drop && lat == 1) begin
                req   = 1'b0;
                addr  = 32'hFFFF_FFFC;
                wdata = 32'h0;
                #1;
            end
            if (ack === 1'b1) begin
                got = 1;
            end else begin
                vectors++;
                if (stall !== req) begin
                    miscompares++;
                    $display("FAIL %s stall_wait: got %b want %b (cycle %0d)", name, stall, req, lat);
                end
            end
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s ack_timeout: got no ack want ack after %0d cycles", name, exp_lat);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if (lat != exp_lat) begin
                miscompares++;
                $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
            end
            vectors++;
            if (rdata !== e.rdata) begin
                miscompares++;
                $display("FAIL %s rdata: got %h want %h", name, rdata, e.rdata);
            end
            vectors++;
            if (err !== e.err) begin
                miscompares++;
                $display("FAIL %s err: got %b want %b", name, err, e.err);
            end
            vectors++;
            if (stall !== 1'b0) begin
                miscompares++;
                $display("FAIL %s stall_at_ack: got %b want 0", name, stall);
            end
        end
        if (!keep_req) req = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (ack !== 1'b0 || rdata !== 32'h0 || err !== 1'b0 || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got ack=%b rdata=%h err=%b stall=%b want 0/0/0/0",
                     ack, rdata, err, stall);
        end
        access(1'b1, 32'h8, 32'hCAFE_F00D, 0, 0, 0, 3, "rst_pre_store");
        access(1'b0, 32'h8, 32'h0, 0, 0, 0, 3, "rst_pre_load");
        req = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        model_rdata = 32'h0;
        vectors++;
        if (ack !== 1'b0 || rdata !== 32'h0 || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got ack=%b rdata=%h stall=%b want 0/00000000/1", ack, rdata, stall);
        end
        req = 1'b0;
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall_follow: got %b want 0", stall);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 3, "store_10");
        access(1'b0, 32'h10, 32'h0, 0, 0, 0, 3, "load_10");
    endtask

    task automatic test_wrap();
        access(1'b1, 32'h10, 32'h0000_1234, 0, 0, 0, 3, "wrap_store");
        access(1'b0, 32'h1010, 32'h0, 0, 0, 0, 3, "wrap_load");
    endtask

    task automatic test_drop_req();
        access(1'b1, 32'h20, 32'h0000_0055, 0, 0, 1, 3, "drop_store");
        access(1'b0, 32'h20, 32'h0, 0, 0, 0, 3, "drop_load");
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        access(1'b1, 32'h30, 32'h0000_0011, 0, 0, 0, 3, "abort_old");
        @(posedge clk);
        @(negedge clk);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h30;
        wdata = 32'h0000_00AA;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        req = 1'b0;
        model_rdata = 32'h0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ack === 1'b1) seen = 1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL abort_no_ack: got ack pulse want none");
        end
        access(1'b0, 32'h30, 32'h0, 0, 0, 0, 3, "abort_load");
    endtask

    task automatic test_align();
        access(1'b1, 32'h10, 32'h0000_1234, 0, 0, 0, 3, "align_prep");
        access(1'b0, 32'h20, 32'h0, 0, 0, 0, 3, "align_prime");
        access(1'b0, 32'h13, 32'h0, 0, 0, 0, 3, "align_load_13");
        access(1'b1, 32'h22, 32'h0000_0077, 0, 0, 0, 3, "align_store_22");
        access(1'b0, 32'h20, 32'h0, 0, 0, 0, 3, "align_check_20");
    endtask

    task automatic test_back_to_back();
        access(1'b1, 32'h40, 32'hA5A5_0001, 0, 1, 0, 3, "b2b_store");
        access(1'b0, 32'h40, 32'h0, 1, 1, 0, 4, "b2b_load");
        access(1'b1, 32'h44, 32'h5A5A_0002, 1, 1, 0, 4, "b2b_store2");
        access(1'b0, 32'h44, 32'h0, 1, 0, 0, 4, "b2b_load2");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_rdata = 32'h0;
        rst   = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_store_load();
        test_wrap();
        test_drop_req();
        test_reset_in_wait();
        test_align();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
